// File: rtl/gate_sweep_ctrl.sv
// Clocked self-test sequencer for the and_nand / or_nor gate pair: walks {in1,in0} through 00..11,
// samples all four gate outputs after settling, and reports per-vector and overall results.
// Optional: define GATE_SWEEP_ERR_COUNT_EN to add a saturating failed-sweep counter (err_count).
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        and_out,
    input  logic        nand_out,
    input  logic        or_out,
    input  logic        nor_out,
    output logic        in0,
    output logic        in1,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_mask,
    output logic [15:0] result_vec
`ifdef GATE_SWEEP_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [3:0]       err_q, err_d;
    logic [15:0]      res_q, res_d;

    logic [3:0] got_nib, exp_nib;
    logic       exp_and, exp_or;

    assign got_nib = {nor_out, or_out, nand_out, and_out};
    assign exp_and = vec_q[1] & vec_q[0];
    assign exp_or  = vec_q[1] | vec_q[0];
    assign exp_nib = {~exp_or, exp_or, ~exp_and, exp_and};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'b00;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= 4'b0000;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    vec_d   = 2'b00;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = 4'b0000;
                    res_d   = 16'h0000;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1))
                    state_d = SAMPLE;
            end
            SAMPLE: begin
                res_d[{vec_q, 2'b00} +: 4] = got_nib;
                err_d[vec_q]               = (got_nib != exp_nib);
                if (vec_q == 2'd3) begin
                    state_d = DONE;
                    pass_d  = ~|err_d;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The vector index register is the gate drive; it holds 2'b11 after a sweep.
    assign in1        = vec_q[1];
    assign in0        = vec_q[0];
    assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign err_mask   = err_q;
    assign result_vec = res_q;

`ifdef GATE_SWEEP_ERR_COUNT_EN
    logic [7:0] errc_q;

    // Survives start; only rst clears the tally.
    always_ff @(posedge clk) begin
        if (rst)
            errc_q <= 8'h00;
        else if (state_q == DONE && !pass_q && errc_q != 8'hFF)
            errc_q <= errc_q + 8'h01;
    end

    assign err_count = errc_q;
`else
    // Failed sweeps are not tallied in this build.
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: default-settle instance with injectable AND fault,
// plus a SETTLE_CYCLES=1 instance with good gates.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic force_and0 = 1'b0;

    logic in0_0, in1_0, busy0, done0, pass0;
    logic [3:0]  err0;
    logic [15:0] res0;
    logic in0_1, in1_1, busy1, done1, pass1;
    logic [3:0]  err1;
    logic [15:0] res1;
`ifdef GATE_SWEEP_ERR_COUNT_EN
    logic [7:0] errc0, errc1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gate_sweep_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .and_out(in1_0 & in0_0 & ~force_and0), .nand_out(~(in1_0 & in0_0)),
        .or_out(in1_0 | in0_0), .nor_out(~(in1_0 | in0_0)),
        .in0(in0_0), .in1(in1_0), .busy(busy0), .done(done0), .pass(pass0),
        .err_mask(err0), .result_vec(res0)
`ifdef GATE_SWEEP_ERR_COUNT_EN
        , .err_count(errc0)
`endif
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .and_out(in1_1 & in0_1), .nand_out(~(in1_1 & in0_1)),
        .or_out(in1_1 | in0_1), .nor_out(~(in1_1 | in0_1)),
        .in0(in0_1), .in1(in1_1), .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(err1), .result_vec(res1)
`ifdef GATE_SWEEP_ERR_COUNT_EN
        , .err_count(errc1)
`endif
    );

    // Leaves the bench at the negedge just after the accepting edge (cycle k=0).
    task automatic pulse_start0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got = {in1_0, in0_0, busy0, done0, pass0, err0, res0};
            n_checks++;
            if (got !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %h want 0", k, got);
            end
            got = {in1_1, in0_1, busy1, done1, pass1, err1, res1};
            n_checks++;
            if (got !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_idle_s1 cyc%0d: got %h want 0", k, got);
            end
        end
    endtask

    task automatic test_good_sweep();
        logic [1:0] exp_in;
        pulse_start0();
        for (int k = 0; k < 22; k++) begin
            exp_in = (k >= 20) ? 2'd3 : 2'(k / 5);
            n_checks++;
            if ({in1_0, in0_0} !== exp_in || busy0 !== (k < 20) || done0 !== (k == 20)) begin
                n_fail++;
                $display("FAIL good_seq k=%0d: in=%b busy=%b done=%b want in=%b busy=%b done=%b",
                         k, {in1_0, in0_0}, busy0, done0, exp_in, k < 20, k == 20);
            end
            if (k == 20) begin
                n_checks++;
                if (pass0 !== 1'b1 || err0 !== 4'b0000 || res0 !== 16'h566A) begin
                    n_fail++;
                    $display("FAIL good_result: pass=%b err=%b res=%h want 1 0000 566A",
                             pass0, err0, res0);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_and_fault();
        force_and0 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            pulse_start0();
            repeat (21) @(negedge clk);
            n_checks++;
            if (pass0 !== 1'b0 || err0 !== 4'b1000 || res0 !== 16'h466A) begin
                n_fail++;
                $display("FAIL and_fault s%0d: pass=%b err=%b res=%h want 0 1000 466A",
                         s, pass0, err0, res0);
            end
        end
`ifdef GATE_SWEEP_ERR_COUNT_EN
        n_checks++;
        if (errc0 !== 8'd2) begin
            n_fail++;
            $display("FAIL err_count: got %0d want 2", errc0);
        end
`endif
        force_and0 = 1'b0;
    endtask

    task automatic test_start_ignored_and_abort();
        int ndone = 0;
        pulse_start0();
        for (int k = 0; k < 24; k++) begin
            if (k == 6) start0 = 1'b1;
            if (k == 7) start0 = 1'b0;
            if (done0 === 1'b1) ndone++;
            @(negedge clk);
        end
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL start_ignored: done pulses=%0d want 1", ndone);
        end
        n_checks++;
        if (pass0 !== 1'b1 || res0 !== 16'h566A) begin
            n_fail++;
            $display("FAIL start_ignored_result: pass=%b res=%h want 1 566A", pass0, res0);
        end
        pulse_start0();
        ndone = 0;
        for (int k = 0; k < 26; k++) begin
            if (k == 10) rst = 1'b1;
            if (k == 11) begin
                rst = 1'b0;
                n_checks++;
                if ({in1_0, in0_0, busy0, pass0, err0, res0} !== 24'd0) begin
                    n_fail++;
                    $display("FAIL abort_reset: in=%b busy=%b pass=%b err=%b res=%h want all 0",
                             {in1_0, in0_0}, busy0, pass0, err0, res0);
                end
            end
            if (k > 11 && (done0 === 1'b1 || busy0 === 1'b1)) ndone++;
            @(negedge clk);
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: busy/done cycles after reset=%0d want 0", ndone);
        end
    endtask

    task automatic test_settle1();
        logic [1:0] exp_in;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_in = (k >= 8) ? 2'd3 : 2'(k / 2);
            n_checks++;
            if ({in1_1, in0_1} !== exp_in || busy1 !== (k < 8) || done1 !== (k == 8)) begin
                n_fail++;
                $display("FAIL settle1_seq k=%0d: in=%b busy=%b done=%b want in=%b busy=%b done=%b",
                         k, {in1_1, in0_1}, busy1, done1, exp_in, k < 8, k == 8);
            end
            if (k == 8) begin
                n_checks++;
                if (pass1 !== 1'b1 || err1 !== 4'b0000 || res1 !== 16'h566A) begin
                    n_fail++;
                    $display("FAIL settle1_result: pass=%b err=%b res=%h want 1 0000 566A",
                             pass1, err1, res1);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 50; k++) begin
            n_checks++;
            if (done0 !== (k == 20 || k == 42)) begin
                n_fail++;
                $display("FAIL b2b_done k=%0d: got %b want %b", k, done0, k == 20 || k == 42);
            end
            if (k == 20 || k == 42) begin
                n_checks++;
                if (pass0 !== 1'b1 || res0 !== 16'h566A) begin
                    n_fail++;
                    $display("FAIL b2b_result k=%0d: pass=%b res=%h want 1 566A", k, pass0, res0);
                end
            end
            if (k == 21 || k == 22) begin
                n_checks++;
                if (busy0 !== (k == 22) || (k == 22 && (res0 !== 16'h0000 || pass0 !== 1'b0))) begin
                    n_fail++;
                    $display("FAIL b2b_reaccept k=%0d: busy=%b res=%h pass=%b", k, busy0, res0, pass0);
                end
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || pass0 !== 1'b1 || {in1_0, in0_0} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b pass=%b in=%b want 0 1 11", busy0, pass0, {in1_0, in0_0});
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_and_fault();
        test_start_ignored_and_abort();
        test_settle1();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
